// File: rtl/sm_datapath.sv
// Datapath for the N-bit shift-add sequential multiplier: md/mr/rs registers plus a
// valid/ready product output stage. Optional illegal-control checking via SM_DP_ERRCHK_EN.
module sm_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   md_in,
  input  logic [N-1:0]   mr_in,
  input  logic           mdld,
  input  logic           mrld,
  input  logic           rsload,
  input  logic           rsclear,
  input  logic           rsshr,
  input  logic           done,
  input  logic           prod_rdy,
  output logic [N-1:0]   mr,
  output logic [2*N:0]   rs_q,
  output logic [2*N-1:0] prod,
  output logic           prod_vld,
  output logic           ovr,
  output logic           err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e     state_q, state_d;
  logic [N-1:0]   md_q, md_d;
  logic [N-1:0]   mr_q, mr_d;
  logic [2*N:0]   rs_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           ovr_q, ovr_d;
  logic [N:0]     sum_s;

  // Operand and running-sum next state; rsclear outranks rsload outranks rsshr.
  always_comb begin
    md_d  = md_q;
    mr_d  = mr_q;
    rs_d  = rs_q;
    sum_s = {1'b0, rs_q[2*N-1:N]} + {1'b0, md_q};
    if (mdld) begin
      md_d = md_in;
    end else begin
      md_d = md_q;
    end
    if (mrld) begin
      mr_d = mr_in;
    end else begin
      mr_d = mr_q;
    end
    if (rsclear) begin
      rs_d = '0;
    end else if (rsload) begin
      rs_d = {sum_s, rs_q[N-1:0]};
    end else if (rsshr) begin
      rs_d = {1'b0, rs_q[2*N:1]};
    end else begin
      rs_d = rs_q;
    end
  end

  // Output handshake: capture on done, drain on transfer, flag overwrite of an unaccepted product.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    ovr_d   = ovr_q;
    case (state_q)
      EMPTY: begin
        if (done) begin
          state_d = FULL;
          prod_d  = rs_q[2*N-1:0];
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (done) begin
          state_d = FULL;
          prod_d  = rs_q[2*N-1:0];
          if (!prod_rdy) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
        end else if (prod_rdy) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      md_q    <= '0;
      mr_q    <= '0;
      rs_q    <= '0;
      prod_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      mr_q    <= mr_d;
      rs_q    <= rs_d;
      prod_q  <= prod_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mr       = mr_q;
  assign prod     = prod_q;
  assign prod_vld = (state_q == FULL);
  assign ovr      = ovr_q;

`ifdef SM_DP_ERRCHK_EN
  logic err_q;
  logic bad_s;

  assign bad_s = (rsclear & rsload) | (rsclear & rsshr) | (rsload & rsshr)
               | (done & (rsload | rsshr));

  // Sticky illegal-control flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bad_s;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
